// File: rtl/vga_timing_ctrl_pkg.sv
// Shared 640x480@60 timing defaults, raster phase type and phase decode.
package vga_timing_pkg;

    localparam int CLK_DIV_DEF  = 4;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF
                           + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF
                           + V_SYNC_DEF + V_BP_DEF;

    localparam logic SYNC_POL_DEF = 1'b0;
    localparam int   COORD_W      = 10;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_t;

    function automatic phase_t phase_of(
        input int cnt,
        input int act,
        input int fp,
        input int sync
    );
        phase_t ph;
        ph = PH_BP;
        unique case (1'b1)
            (cnt < act):             ph = PH_ACTIVE;
            (cnt >= act && cnt < act + fp):
                                     ph = PH_FP;
            (cnt >= act + fp && cnt < act + fp + sync):
                                     ph = PH_SYNC;
            default:                 ph = PH_BP;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Raster output bundle from the timing controller to image-fetch logic.
interface vga_timing_ctrl_if;
    import vga_timing_pkg::*;

    logic               pix_en;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               line_start;
    logic               frame_start;

    modport master (
        output pix_en, hsync, vsync, video_on,
        output x, y, line_start, frame_start
    );

    modport slave (
        input pix_en, hsync, vsync, video_on,
        input x, y, line_start, frame_start
    );

endinterface

// File: rtl/vga_timing_ctrl_strobe.sv
// Divides the system clock into a one-cycle pixel strobe.
module pixel_strobe_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic pix_en_o,
    output logic pix_next_o
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          pix_en_q;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    // Lets the parent register strobe-aligned pulses in the same edge.
    assign pix_next_o = en_i && !rst_i && (div_q == DIV_LAST);
    assign pix_en_o   = pix_en_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= (div_q == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: H/V counters stepped on the pixel strobe.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = CLK_DIV_DEF,
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input  logic             clk100MHz,
    input  logic             reset,
    input  logic             enable,
    vga_timing_ctrl_if.master vga
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);

    logic               pix_en;
    logic               pix_next;
    logic [HW-1:0]      h_q, h_d;
    logic [VW-1:0]      v_q, v_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               vid_q, vid_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               ls_q, ls_d;
    logic               fs_q, fs_d;
    phase_t             ph_h, ph_v;

    pixel_strobe_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe (
        .clk_i      (clk100MHz),
        .rst_i      (reset),
        .en_i       (enable),
        .pix_en_o   (pix_en),
        .pix_next_o (pix_next)
    );

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + HW'(1);
            if (h_q == H_LAST) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end
        end
    end

    // Decode the post-update position so outputs trail pix_en by one cycle.
    always_comb begin
        ph_h  = phase_of(int'(h_d), H_ACTIVE, H_FP, H_SYNC);
        ph_v  = phase_of(int'(v_d), V_ACTIVE, V_FP, V_SYNC);
        vid_d = (ph_h == PH_ACTIVE) && (ph_v == PH_ACTIVE);
        hs_d  = (ph_h == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_d  = (ph_v == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        x_d   = vid_d ? COORD_W'(h_d) : '0;
        y_d   = vid_d ? COORD_W'(v_d) : '0;
        ls_d  = pix_next && (h_q == H_LAST);
        fs_d  = ls_d && (v_q == V_LAST);
    end

    always_ff @(posedge clk100MHz) begin
        if (reset || !enable) begin
            h_q   <= H_LAST;
            v_q   <= V_LAST;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            vid_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            if (pix_en) begin
                hs_q  <= hs_d;
                vs_q  <= vs_d;
                vid_q <= vid_d;
                x_q   <= x_d;
                y_q   <= y_d;
            end
        end
    end

    assign vga.pix_en      = pix_en;
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.video_on    = vid_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: default 640x480 and a shrunk raster.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, a_en, b_rst, b_en;

    vga_timing_ctrl_if a_if ();
    vga_timing_ctrl_if b_if ();

    vga_timing_ctrl dut_a (
        .clk100MHz (clk),
        .reset     (a_rst),
        .enable    (a_en),
        .vga       (a_if.master)
    );

    vga_timing_ctrl #(
        .CLK_DIV  (2),
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_b (
        .clk100MHz (clk),
        .reset     (b_rst),
        .enable    (b_en),
        .vga       (b_if.master)
    );

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] IDLE  = {6'd0, 6'b011000, 20'd0};
    localparam logic [31:0] PIX00 = {6'd0, 6'b011100, 20'd0};

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] a_vec();
        return {6'd0, a_if.pix_en, a_if.hsync, a_if.vsync,
                a_if.video_on, a_if.line_start,
                a_if.frame_start, a_if.x, a_if.y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gap, bad_gap, nstrobe, vid_lo, hs_lo, hs_first;
        int xmax, xerr, ls_t, hcur, vcur, prev, anypix;
        int vid_n, vs_n, vs_first, ymax, lserr, fserr;
        int frames, fs_t, fs_wait;

        a_rst = 1'b1; a_en = 1'b1;
        b_rst = 1'b1; b_en = 1'b1;

        // 1: reset with enable high, then first strobe
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rst_idle%0d", i), a_vec(), IDLE);
        end
        a_rst = 1'b0;
        anypix = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (a_if.pix_en) anypix = 1;
        end
        chk("pre_strobe_quiet", anypix, 0);
        step();
        chk("first_strobe",
            {a_if.pix_en, a_if.line_start,
             a_if.frame_start, a_if.video_on}, 4'b1110);
        step();
        chk("first_pixel", a_vec(), PIX00);

        // 2: one full line
        gap = 1; bad_gap = 0; nstrobe = 0; vid_lo = 0;
        hs_lo = 0; hs_first = -1; xmax = 0; xerr = 0;
        ls_t = -1; hcur = 0; prev = 0;
        for (int t = 1; t <= 3200; t++) begin
            step();
            gap++;
            if (prev != 0) begin
                hcur = (hcur + 1) % 800;
                if (!a_if.video_on) vid_lo++;
                else begin
                    if (int'(a_if.x) != hcur) xerr++;
                    if (int'(a_if.x) > xmax) xmax = int'(a_if.x);
                end
                if (!a_if.hsync) begin
                    hs_lo++;
                    if (hs_first < 0) hs_first = hcur;
                end
            end
            prev = a_if.pix_en;
            if (a_if.pix_en) begin
                nstrobe++;
                if (gap != 4) bad_gap++;
                gap = 0;
                if (a_if.line_start) ls_t = t;
            end
        end
        chk("pix_gap_errors", bad_gap, 0);
        chk("strobes_per_line", nstrobe, 800);
        chk("video_off_strobes", vid_lo, 160);
        chk("hsync_low_strobes", hs_lo, 96);
        chk("hsync_first_h", hs_first, 656);
        chk("x_max", xmax, 639);
        chk("x_track_errors", xerr, 0);
        chk("line_start_period", ls_t + 1, 3200);
        chk("line1_y", a_if.y, 1);

        // 4: drop enable mid-line inside hsync
        for (int i = 0; i < 4000; i++) begin
            step();
            if (prev != 0) hcur++;
            prev = a_if.pix_en;
            if (hcur == 700) break;
        end
        chk("reach_h700", hcur, 700);
        chk("pre_drop_hsync", a_if.hsync, 0);
        a_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("dis_idle%0d", i), a_vec(), IDLE);
        end
        a_en = 1'b1;
        anypix = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (a_if.pix_en) anypix = 1;
        end
        chk("reen_quiet", anypix, 0);
        step();
        chk("reen_strobe",
            {a_if.pix_en, a_if.line_start, a_if.frame_start},
            3'b111);
        step();
        chk("reen_pixel", a_vec(), PIX00);

        // 5: reset inside hsync pulse
        hcur = 0; prev = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (prev != 0) hcur++;
            prev = a_if.pix_en;
            if (!a_if.hsync) break;
        end
        chk("hsync_found_h", hcur, 656);
        a_rst = 1'b1;
        step();
        chk("rst_in_hsync", a_vec(), IDLE);
        a_rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        step();
        chk("rst_restart_strobe",
            {a_if.pix_en, a_if.line_start, a_if.frame_start},
            3'b111);

        // 6/3: shrunk raster, CLK_DIV=2, 12x7
        b_rst = 1'b0;
        fs_wait = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (b_if.frame_start) begin
                fs_wait = i;
                break;
            end
        end
        chk("b_first_fs_clock", fs_wait, 2);
        hcur = 0; vcur = 0; prev = 1; gap = 0; frames = 1;
        fs_t = -1; bad_gap = 0; vid_n = 0; hs_lo = 0;
        hs_first = -1; vs_n = 0; vs_first = -1; xmax = 0;
        ymax = 0; xerr = 0; lserr = 0; fserr = 0;
        for (int t = 1; t <= 400; t++) begin
            step();
            gap++;
            if (prev != 0) begin
                if (b_if.video_on) begin
                    vid_n++;
                    if (int'(b_if.x) != hcur) xerr++;
                    if (int'(b_if.y) != vcur) xerr++;
                    if (int'(b_if.x) > xmax) xmax = int'(b_if.x);
                    if (int'(b_if.y) > ymax) ymax = int'(b_if.y);
                end
                if (!b_if.hsync) begin
                    hs_lo++;
                    if (hs_first < 0) hs_first = hcur;
                end
                if (!b_if.vsync) begin
                    vs_n++;
                    if (vs_first < 0) vs_first = vcur;
                end
            end
            prev = b_if.pix_en;
            if (b_if.pix_en) begin
                if (gap != 2) bad_gap++;
                gap = 0;
                hcur++;
                if (hcur == 12) begin
                    hcur = 0;
                    vcur = (vcur + 1) % 7;
                end
                if (b_if.line_start !== (hcur == 0)) lserr++;
                if (b_if.frame_start !==
                    (hcur == 0 && vcur == 0)) fserr++;
                if (b_if.frame_start) begin
                    fs_t = t;
                    frames++;
                    break;
                end
            end
        end
        chk("b_pix_gap_errors", bad_gap, 0);
        chk("b_frame_period", fs_t, 168);
        chk("b_video_strobes", vid_n, 32);
        chk("b_hsync_strobes", hs_lo, 14);
        chk("b_hsync_first_h", hs_first, 9);
        chk("b_vsync_strobes", vs_n, 12);
        chk("b_vsync_first_v", vs_first, 5);
        chk("b_x_max", xmax, 7);
        chk("b_y_max", ymax, 3);
        chk("b_xy_errors", xerr, 0);
        chk("b_line_start_errors", lserr, 0);
        chk("b_frame_start_errors", fserr, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
